// File: rtl/lcd_init_sequencer.sv
// HD44780 4-bit power-on initialisation and byte-to-nibble sequencer.
// Sole master of the lcd_interface nibble handshake.
module lcd_init_sequencer #(
  parameter int POWERON_CYCLES    = 1080000,
  parameter int INIT_WAIT_CYCLES  = 110700,
  parameter int SHORT_WAIT_CYCLES = 2700,
  parameter int GUARD_CYCLES      = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_reinit,
  input  logic       i_req_valid,
  input  logic       i_req_rs,
  input  logic [7:0] i_req_data,
  output logic       o_req_ready,
  output logic       o_init_done,
  output logic [3:0] o_nib_data,
  output logic       o_nib_valid,
  output logic       o_nib_rs,
  input  logic       i_if_ready
);

  localparam int MAX_A    = (POWERON_CYCLES > INIT_WAIT_CYCLES) ? POWERON_CYCLES : INIT_WAIT_CYCLES;
  localparam int MAX_WAIT = (MAX_A > SHORT_WAIT_CYCLES) ? MAX_A : SHORT_WAIT_CYCLES;
  localparam int CW       = $clog2(MAX_WAIT) + 1;
  localparam int GW       = $clog2(GUARD_CYCLES + 1) + 1;

  localparam logic [CW-1:0] POWERON_LOAD = CW'(POWERON_CYCLES - 1);
  localparam logic [CW-1:0] INIT_LOAD    = CW'(INIT_WAIT_CYCLES - 1);
  localparam logic [CW-1:0] SHORT_LOAD   = CW'(SHORT_WAIT_CYCLES - 1);
  localparam logic [GW-1:0] GUARD_LOAD   = GW'(GUARD_CYCLES);

  typedef enum logic [2:0] {
    POWERON, INIT_NIB, INIT_DELAY, INIT_CMD, IDLE, SEND_HI, SEND_LO
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] wait_cnt, wait_cnt_next;
  logic          wait_armed, armed_next;
  logic [GW-1:0] guard_cnt, guard_next;
  logic          pending, pending_next;
  logic [1:0]    init_idx, init_idx_next;
  logic [2:0]    cmd_idx, cmd_idx_next;
  logic [7:0]    byte_q, byte_next;
  logic          byte_rs, byte_rs_next;
  logic          cmd_mode, cmd_mode_next;
  logic          init_done_q, done_next;
  logic          reinit_pend, reinit_next;
  logic [3:0]    nib_q, nib_next;
  logic          nib_rs_q, nib_rs_next;
  logic          strobe, nib_done, req_ready, restart;
  logic [7:0]    cmd_cur;

  function automatic logic [7:0] cmd_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    cmd_byte = 8'h28;
      3'd1:    cmd_byte = 8'h08;
      3'd2:    cmd_byte = 8'h01;
      3'd3:    cmd_byte = 8'h06;
      default: cmd_byte = 8'h0C;
    endcase
  endfunction

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= POWERON;
      wait_cnt    <= '0;
      wait_armed  <= 1'b0;
      guard_cnt   <= '0;
      pending     <= 1'b0;
      init_idx    <= '0;
      cmd_idx     <= '0;
      byte_q      <= '0;
      byte_rs     <= 1'b0;
      cmd_mode    <= 1'b0;
      init_done_q <= 1'b0;
      reinit_pend <= 1'b0;
      nib_q       <= '0;
      nib_rs_q    <= 1'b0;
    end else begin
      state       <= state_next;
      wait_cnt    <= wait_cnt_next;
      wait_armed  <= armed_next;
      guard_cnt   <= guard_next;
      pending     <= pending_next;
      init_idx    <= init_idx_next;
      cmd_idx     <= cmd_idx_next;
      byte_q      <= byte_next;
      byte_rs     <= byte_rs_next;
      cmd_mode    <= cmd_mode_next;
      init_done_q <= done_next;
      reinit_pend <= reinit_next;
      nib_q       <= nib_next;
      nib_rs_q    <= nib_rs_next;
    end
  end

  // The nibble register is loaded on entry to an issuing state so it is stable before any strobe.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    armed_next    = wait_armed;
    guard_next    = guard_cnt;
    pending_next  = pending;
    init_idx_next = init_idx;
    cmd_idx_next  = cmd_idx;
    byte_next     = byte_q;
    byte_rs_next  = byte_rs;
    cmd_mode_next = cmd_mode;
    done_next     = init_done_q;
    reinit_next   = reinit_pend | i_reinit;
    nib_next      = nib_q;
    nib_rs_next   = nib_rs_q;
    restart       = 1'b0;
    cmd_cur       = cmd_byte(cmd_idx);

    if (strobe) begin
      pending_next = 1'b1;
      guard_next   = GUARD_LOAD;
    end else if (pending && guard_cnt != '0) begin
      guard_next = guard_cnt - 1'b1;
    end
    if (nib_done) pending_next = 1'b0;

    case (state)
      POWERON: begin
        if (reinit_pend) restart = 1'b1;
        else if (!wait_armed) begin
          wait_cnt_next = POWERON_LOAD;
          armed_next    = 1'b1;
        end else if (wait_cnt != '0) wait_cnt_next = wait_cnt - 1'b1;
        else begin
          state_next    = INIT_NIB;
          init_idx_next = 2'd0;
          nib_next      = 4'h3;
          nib_rs_next   = 1'b0;
        end
      end
      INIT_NIB: if (nib_done) begin
        if (reinit_pend) restart = 1'b1;
        else begin
          state_next    = INIT_DELAY;
          wait_cnt_next = (init_idx == 2'd0) ? INIT_LOAD : SHORT_LOAD;
        end
      end
      INIT_DELAY: begin
        if (reinit_pend) restart = 1'b1;
        else if (wait_cnt != '0) wait_cnt_next = wait_cnt - 1'b1;
        else if (init_idx == 2'd3) begin
          state_next   = INIT_CMD;
          cmd_idx_next = 3'd0;
        end else begin
          state_next    = INIT_NIB;
          init_idx_next = init_idx + 2'd1;
          nib_next      = (init_idx == 2'd2) ? 4'h2 : 4'h3;
          nib_rs_next   = 1'b0;
        end
      end
      INIT_CMD: begin
        if (reinit_pend) restart = 1'b1;
        else begin
          state_next    = SEND_HI;
          byte_next     = cmd_cur;
          byte_rs_next  = 1'b0;
          cmd_mode_next = 1'b1;
          nib_next      = cmd_cur[7:4];
          nib_rs_next   = 1'b0;
        end
      end
      IDLE: begin
        if (reinit_pend) restart = 1'b1;
        else if (i_req_valid && req_ready) begin
          state_next    = SEND_HI;
          byte_next     = i_req_data;
          byte_rs_next  = i_req_rs;
          cmd_mode_next = 1'b0;
          nib_next      = i_req_data[7:4];
          nib_rs_next   = i_req_rs;
        end
      end
      SEND_HI: if (nib_done) begin
        state_next  = SEND_LO;
        nib_next    = byte_q[3:0];
        nib_rs_next = byte_rs;
      end
      SEND_LO: if (nib_done) begin
        if (reinit_pend) restart = 1'b1;
        else if (cmd_mode && cmd_idx != 3'd4) begin
          state_next   = INIT_CMD;
          cmd_idx_next = cmd_idx + 3'd1;
        end else begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = POWERON;
    endcase

    if (restart) begin
      state_next    = POWERON;
      wait_cnt_next = POWERON_LOAD;
      armed_next    = 1'b1;
      reinit_next   = 1'b0;
      done_next     = 1'b0;
    end
    if (i_reinit) begin
      done_next   = 1'b0;
      reinit_next = 1'b1;
    end
  end

  always_comb begin
    strobe      = (state == INIT_NIB || state == SEND_HI || state == SEND_LO) && !pending && i_if_ready;
    nib_done    = pending && (guard_cnt == '0) && i_if_ready;
    req_ready   = (state == IDLE) && init_done_q && !reinit_pend && !pending;
    o_req_ready = req_ready;
    o_init_done = init_done_q;
    o_nib_valid = strobe;
    o_nib_data  = nib_q;
    o_nib_rs    = nib_rs_q;
  end

endmodule

// File: doc/lcd_init_sequencer.md
Name: lcd_init_sequencer

Overview:
Controller that sequences the 4-bit LCD nibble interface (lcd_interface) for an HD44780-compatible display. After reset it runs the power-on 4-bit initialisation sequence. It then accepts full-byte command/character requests from the clock/UI logic and splits each byte into high and low nibbles. It is the only master of lcd_interface's nibble handshake.

Parameters:
POWERON_CYCLES, 1080000, idle cycles after reset before the first nibble (40 ms at 27 MHz)
INIT_WAIT_CYCLES, 110700, wait after first init nibble (4.1 ms)
SHORT_WAIT_CYCLES, 2700, wait after init nibbles 2-4 (100 us)
GUARD_CYCLES, 2, cycles i_if_ready is ignored after issuing a nibble

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous reset, active-high
i_reinit  in  1  single-cycle pulse: restart full init sequence
i_req_valid  in  1  byte request valid
i_req_rs  in  1  register select for request (0 = command, 1 = data)
i_req_data  in  8  byte to send
o_req_ready  out  1  request accepted when i_req_valid && o_req_ready
o_init_done  out  1  init sequence complete
o_nib_data  out  4  nibble to lcd_interface i_display_data
o_nib_valid  out  1  one-cycle nibble strobe to i_display_data_valid
o_nib_rs  out  1  to lcd_interface i_RS
i_if_ready  in  1  from lcd_interface o_is_ready

Behaviour:
- One clock (i_clk); reset is asynchronous and active-high (i_rst).
- Reset values: o_nib_valid = 0, o_nib_data = 0, o_nib_rs = 0, o_req_ready = 0, o_init_done = 0. State is POWERON. Counters are cleared.
- Nibble issue rule:
  - o_nib_valid pulses for exactly 1 cycle, and only in a cycle where i_if_ready = 1.
  - o_nib_data and o_nib_rs are registered and stable on the strobe cycle.
  - For the next GUARD_CYCLES cycles i_if_ready is ignored. After that, the nibble is complete when i_if_ready = 1.
- States:
  - POWERON: count POWERON_CYCLES, then go to INIT_NIB with index 0.
  - INIT_NIB: issue timed nibbles 3, 3, 3, 2 (RS = 0). After each one completes, go to INIT_DELAY.
  - INIT_DELAY: wait INIT_WAIT_CYCLES after index 0, or SHORT_WAIT_CYCLES after indices 1-3. Then take the next nibble, or go to INIT_CMD after index 3.
  - INIT_CMD: send bytes 0x28, 0x08, 0x01, 0x06, 0x0C (RS = 0) via SEND_HI/SEND_LO. No timed wait; completion is paced by i_if_ready.
  - IDLE: o_init_done = 1 and o_req_ready = 1. On accept, latch data/RS, drop o_req_ready in the next cycle, and go to SEND_HI.
  - SEND_HI: issue data[7:4]. SEND_LO: issue data[3:0]. On low-nibble completion return to IDLE, or to INIT_CMD for the next command byte.
- o_req_ready is 1 only in IDLE with no nibble pending. Requests are never accepted before o_init_done.
- Minimum byte turnaround: o_req_ready is reasserted in the cycle after low-nibble completion.
- i_reinit:
  - Honoured in any state after the current nibble completes. A byte in flight is finished; no half byte is ever left on the bus.
  - o_init_done and o_req_ready clear the cycle after the pulse is registered. The sequence restarts at POWERON.
- i_rst mid-operation: immediate return to reset values and POWERON. The in-flight byte is dropped.
- i_req_valid while o_req_ready = 0: ignored and not latched. The requester holds valid.
- Counters:
  - Width is $clog2 of the largest wait parameter, plus 1.
  - Counters count down from param-1 to 0. Wait length is exact: param cycles.

Test Plan:
Use POWERON = 20, INIT_WAIT = 10, SHORT_WAIT = 4, GUARD = 2. The interface model drops ready for 5 cycles per nibble.
1. Release reset, no requests -> nibble stream 3,3,3,2,2,8,0,8,0,1,0,6,0,C, all RS = 0; first strobe ≥ 20 cycles after reset release; gap between strobes 1 and 2 ≥ 10 cycles + busy time; o_init_done rises after the 0xC nibble completes.
2. Hold i_req_valid = 1, data 0x41, RS = 1 from reset -> o_req_ready stays 0 through init; accepted on the first IDLE cycle; nibbles 4 then 1 with RS = 1.
3. Back-to-back requests 0x80 (RS = 0) then 0x48 (RS = 1) -> nibbles 8, 0, 4, 8 in order; no strobe while i_if_ready = 0 or during guard; o_req_ready low from acceptance until low-nibble completion.
4. Interface model holds ready low for 50 cycles -> no strobe issued; sequencer waits with no timeout and no duplicate nibble.
5. Assert i_rst right after the high nibble of 0x41 -> all outputs at reset values in the same cycle; low nibble never issued; full init repeats after release.
6. Pulse i_reinit during SEND_HI of 0x55 -> low nibble 5 still sent; then o_init_done = 0 and the full init stream of test 1 repeats.
